// File: rtl/controller.sv
// controller: fetch/execute FSM decoding the IR opcode into datapath strobes and mux selects.
module controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Opcode,
  output logic       LoadIR,
  output logic       IncPC,
  output logic       SelPC,
  output logic       LoadPC,
  output logic       LoadReg,
  output logic       LoadAcc,
  output logic [1:0] SelAcc,
  output logic [3:0] SelALU
);
  typedef enum logic [1:0] {RST = 2'b00, FETCH = 2'b01, EXEC = 2'b10, HALT = 2'b11} stateT;
  stateT state;
  logic exec, aluOp;
  always_ff @(posedge clk)
    if (reset) state <= RST;
    else state <= state == RST   ? FETCH :
                  state == FETCH ? EXEC :
                  state == EXEC  ? (Opcode == 4'hF ? HALT : FETCH) : HALT;
  // Opcode is only looked at in EXEC, so junk on it in other states never reaches an output.
  always_comb begin
    exec    = state == EXEC;
    aluOp   = exec && Opcode >= 4'h4 && Opcode <= 4'hA;
    LoadIR  = state == FETCH;
    IncPC   = state == FETCH;
    SelPC   = exec && Opcode == 4'hB;
    LoadPC  = exec && Opcode == 4'hB;
    LoadReg = exec && Opcode == 4'h2;
    LoadAcc = aluOp || (exec && (Opcode == 4'h1 || Opcode == 4'h3));
    SelAcc  = !exec ? 2'b00 : Opcode == 4'h1 ? 2'b01 : Opcode == 4'h3 ? 2'b10 : 2'b00;
    SelALU  = aluOp ? Opcode : 4'h0;
  end
endmodule

// File: tb/tb_controller.sv
// tb_controller: directed vector table plus randomized run against an instruction-level reference model.
module tb_controller;
  logic clk = 1'b0, reset, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc;
  logic [3:0] Opcode, SelALU;
  logic [1:0] SelAcc;
  int passCnt = 0, totalCnt = 0;
  bit inRst = 1'b1, halted = 1'b0, inExec = 1'b0;

  controller dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC),
    .LoadPC(LoadPC), .LoadReg(LoadReg), .LoadAcc(LoadAcc), .SelAcc(SelAcc), .SelALU(SelALU)
  );

  always #5 clk = ~clk;

  // Packed view: {LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc[1:0], SelALU[3:0]}
  localparam logic [11:0] ZERO = 12'h000, FET = 12'hC00, LDI = 12'h050, STR = 12'h080,
                          LDR = 12'h060, JMP = 12'h300, ALU = 12'h040;

  typedef struct {
    logic        r;
    logic [3:0]  op;
    logic [11:0] exp;
    string       name;
  } vecT;
  vecT vecs[$];

  function automatic logic [11:0] modelOut(input logic [3:0] op);
    if (inRst || halted) return ZERO;
    if (!inExec) return FET;
    if (op == 4'd1) return LDI;
    if (op == 4'd2) return STR;
    if (op == 4'd3) return LDR;
    if (op >= 4'd4 && op <= 4'd10) return ALU | {8'h00, op};
    if (op == 4'd11) return JMP;
    return ZERO;
  endfunction

  // Advance the instruction-level model across one rising edge.
  function automatic void modelStep(input logic r, input logic [3:0] op);
    if (r) begin
      inRst = 1'b1; halted = 1'b0; inExec = 1'b0;
    end else if (inRst) begin
      inRst = 1'b0; inExec = 1'b0;
    end else if (!halted) begin
      if (inExec && op == 4'hF) halted = 1'b1;
      inExec = !inExec && !halted ? 1'b1 : 1'b0;
    end
  endfunction

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    totalCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s: got %03h expected %03h", name, got, exp);
  endtask

  task automatic step(input logic r, input logic [3:0] op, input logic [11:0] exp,
                      input bit useModel, input string name);
    logic [11:0] got;
    @(negedge clk);
    reset = r;
    Opcode = op;
    #1;
    got = {LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, SelALU};
    check(name, got, useModel ? modelOut(op) : exp);
    if (!((LoadAcc && LoadReg) || (IncPC && LoadPC))) passCnt++;
    else $display("FAIL exclusive strobes %s: got %03h expected none overlapping", name, got);
    totalCnt++;
    modelStep(r, op);
  endtask

  initial begin
    reset = 1'b1;
    Opcode = 4'h0;
    vecs.push_back('{1'b0, 4'h0, ZERO, "reset RST"});
    vecs.push_back('{1'b0, 4'h1, FET, "first FETCH"});
    vecs.push_back('{1'b0, 4'h1, LDI, "LDI exec"});
    vecs.push_back('{1'b0, 4'h1, FET, "FETCH 2"});
    vecs.push_back('{1'b0, 4'h2, STR, "STR exec"});
    vecs.push_back('{1'b0, 4'h3, FET, "FETCH 3"});
    vecs.push_back('{1'b0, 4'h3, LDR, "LDR exec"});
    vecs.push_back('{1'b0, 4'hB, FET, "FETCH 4"});
    vecs.push_back('{1'b0, 4'hB, JMP, "JMP exec"});
    vecs.push_back('{1'b0, 4'h4, FET, "FETCH ALU op"});
    vecs.push_back('{1'b0, 4'h4, ALU | 12'h004, "ADD exec"});
    vecs.push_back('{1'b0, 4'h4, FET, "FETCH 6"});
    vecs.push_back('{1'b1, 4'h4, ALU | 12'h004, "ADD exec reset"});
    vecs.push_back('{1'b0, 4'h0, ZERO, "abort RST"});
    vecs.push_back('{1'b0, 4'hC, FET, "FETCH 7"});
    vecs.push_back('{1'b0, 4'hC, ZERO, "reserved exec"});
    vecs.push_back('{1'b0, 4'hF, FET, "FETCH 8"});
    vecs.push_back('{1'b0, 4'hF, ZERO, "HLT exec"});
    vecs.push_back('{1'b0, 4'h1, ZERO, "HALT 1"});
    vecs.push_back('{1'b0, 4'h4, ZERO, "HALT 2"});
    vecs.push_back('{1'b1, 4'hB, ZERO, "HALT reset"});
    vecs.push_back('{1'b0, 4'h0, ZERO, "RST after halt"});
    vecs.push_back('{1'b0, 4'h0, FET, "FETCH resumes"});
    vecs.push_back('{1'b0, 4'h0, ZERO, "NOP exec"});
    foreach (vecs[i]) step(vecs[i].r, vecs[i].op, vecs[i].exp, 1'b0, vecs[i].name);
    // ALU sweep: SelALU is zero in FETCH and equals the opcode in EXEC.
    for (int op = 4; op <= 10; op++) begin
      step(1'b0, 4'(op), FET, 1'b0, "sweep FETCH");
      step(1'b0, 4'(op), ALU | 12'(op), 1'b0, "sweep ALU exec");
    end
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 19) == 0, 4'($urandom), ZERO, 1'b1, "random");
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
